// File: rtl/ats_pkg.sv
// ats_pkg: shared widths, FSM encoding and the reserved discard timestamp for the ATS scheduler.
package ats_pkg;
    localparam int TIMESTAMP_WIDTH = 72;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_CMP, ST_OUT} state_t;
    localparam logic [TIMESTAMP_WIDTH-1:0] DISCARD_TIMESTAMP = '0;
endpackage

// File: rtl/ats_len_duration.sv
// ats_len_duration: registered ceil(len * tpb / 2^frac), the frame's bucket drain duration.
module ats_len_duration #(
    parameter int LEN_WIDTH = 16,
    parameter int TPB_WIDTH = 24,
    parameter int TPB_FRAC_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LEN_WIDTH-1:0]           len,
    input  logic [TPB_WIDTH-1:0]           tpb,
    output logic [LEN_WIDTH+TPB_WIDTH-1:0] dur
);
    localparam int PW = LEN_WIDTH + TPB_WIDTH + 1;
    localparam logic [PW-1:0] ROUND = PW'((1 << TPB_FRAC_BITS) - 1);
    logic [PW-1:0] prod;
    assign prod = PW'(len) * PW'(tpb) + ROUND;
    always_ff @(posedge clk or posedge rst)
        if (rst) dur <= '0;
        else dur <= (LEN_WIDTH+TPB_WIDTH)'(prod >> TPB_FRAC_BITS);
endmodule

// File: rtl/ats_eligibility_scheduler.sv
// ats_eligibility_scheduler: per-stream ATS token bucket producing eligibility times (0 = discard).
module ats_eligibility_scheduler
    import ats_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = ats_pkg::TIMESTAMP_WIDTH,
    parameter int LEN_WIDTH = 16,
    parameter int TPB_WIDTH = 24,
    parameter int TPB_FRAC_BITS = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_WIDTH-1:0]       s_req_frame_len,
    input  logic [TIMESTAMP_WIDTH-1:0] s_req_arrival_time,
    input  logic                       s_req_valid,
    output logic                       s_req_ready,
    output logic [TIMESTAMP_WIDTH-1:0] m_axis_timestamp_tdata,
    output logic                       m_axis_timestamp_tvalid,
    input  logic                       m_axis_timestamp_tready,
    input  logic                       cfg_enable,
    input  logic [TPB_WIDTH-1:0]       cfg_time_per_byte,
    input  logic [TIMESTAMP_WIDTH-1:0] cfg_empty_to_full,
    input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence,
    input  logic                       state_clear,
    output logic [CNT_WIDTH-1:0]       discard_count,
    output logic [CNT_WIDTH-1:0]       eligible_count
);
    localparam logic [TIMESTAMP_WIDTH-1:0] ONE = TIMESTAMP_WIDTH'(1);
    state_t state, state_next;
    logic clear_pending, accept, pass, inc_elig, inc_disc;
    logic enable_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [TPB_WIDTH-1:0] tpb_q;
    logic [TIMESTAMP_WIDTH-1:0] arrival_q, e2f_q, mrt_q;
    logic [TIMESTAMP_WIDTH-1:0] bucket_empty_time, group_elig_time;
    logic [LEN_WIDTH+TPB_WIDTH-1:0] len_dur_raw;
    logic [TIMESTAMP_WIDTH-1:0] len_dur, sched, full, elig_ag, elig, result;

    ats_len_duration #(
        .LEN_WIDTH(LEN_WIDTH),
        .TPB_WIDTH(TPB_WIDTH),
        .TPB_FRAC_BITS(TPB_FRAC_BITS)
    ) u_len_duration (
        .clk(clk),
        .rst(rst),
        .len(len_q),
        .tpb(tpb_q),
        .dur(len_dur_raw)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = accept ? ST_MUL : ST_IDLE;
            ST_MUL:  state_next = ST_CMP;
            ST_CMP:  state_next = ST_OUT;
            ST_OUT:  state_next = m_axis_timestamp_tready ? ST_IDLE : ST_OUT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_req_ready = !rst && state == ST_IDLE && !state_clear && !clear_pending;
        m_axis_timestamp_tvalid = state == ST_OUT;
        accept = s_req_valid && s_req_ready;
    end

    always_comb begin
        len_dur = TIMESTAMP_WIDTH'(len_dur_raw);
        sched = bucket_empty_time + len_dur;
        full = bucket_empty_time + e2f_q;
        elig_ag = arrival_q > group_elig_time ? arrival_q : group_elig_time;
        elig = elig_ag > sched ? elig_ag : sched;
        pass = elig <= arrival_q + mrt_q;
        // Zero is reserved for discard, so a passing time of 0 is nudged to 1.
        result = !enable_q ? (arrival_q == '0 ? ONE : arrival_q)
               : pass ? (elig == '0 ? ONE : elig) : DISCARD_TIMESTAMP;
        inc_elig = state == ST_CMP && (!enable_q || pass);
        inc_disc = state == ST_CMP && enable_q && !pass;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clear_pending <= 1'b0;
            bucket_empty_time <= '0;
            group_elig_time <= '0;
            m_axis_timestamp_tdata <= '0;
            discard_count <= '0;
            eligible_count <= '0;
            enable_q <= 1'b0;
            len_q <= '0;
            tpb_q <= '0;
            arrival_q <= '0;
            e2f_q <= '0;
            mrt_q <= '0;
        end else begin
            if (accept) begin
                len_q <= s_req_frame_len;
                arrival_q <= s_req_arrival_time;
                enable_q <= cfg_enable;
                tpb_q <= cfg_time_per_byte;
                e2f_q <= cfg_empty_to_full;
                mrt_q <= cfg_max_residence;
            end
            if (state == ST_IDLE && (state_clear || clear_pending)) begin
                bucket_empty_time <= '0;
                group_elig_time <= '0;
                clear_pending <= 1'b0;
            end else if (state != ST_IDLE && state_clear) begin
                clear_pending <= 1'b1;
            end
            if (state == ST_CMP) begin
                m_axis_timestamp_tdata <= result;
                if (enable_q && pass) begin
                    group_elig_time <= elig;
                    bucket_empty_time <= elig < full ? sched : sched + elig - full;
                end
            end
            if (inc_elig && eligible_count != '1) eligible_count <= eligible_count + 1'b1;
            if (inc_disc && discard_count != '1) discard_count <= discard_count + 1'b1;
        end
endmodule

// File: tb/tb_ats_eligibility_scheduler.sv
// tb_ats_eligibility_scheduler: directed vector table plus hand-written backpressure/clear/reset sequences.
module tb_ats_eligibility_scheduler;
    localparam int TS = 72;
    localparam logic [23:0] TPB = 24'h000800;
    localparam logic [TS-1:0] E2F = 72'd12000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] s_req_frame_len = '0;
    logic [TS-1:0] s_req_arrival_time = '0;
    logic s_req_valid = 1'b0;
    logic s_req_ready;
    logic [TS-1:0] m_axis_timestamp_tdata;
    logic m_axis_timestamp_tvalid;
    logic m_axis_timestamp_tready = 1'b1;
    logic cfg_enable = 1'b1;
    logic [23:0] cfg_time_per_byte = TPB;
    logic [TS-1:0] cfg_empty_to_full = E2F;
    logic [TS-1:0] cfg_max_residence = 72'd100000;
    logic state_clear = 1'b0;
    logic [31:0] discard_count, eligible_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ats_eligibility_scheduler dut (
        .clk(clk),
        .rst(rst),
        .s_req_frame_len(s_req_frame_len),
        .s_req_arrival_time(s_req_arrival_time),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .m_axis_timestamp_tdata(m_axis_timestamp_tdata),
        .m_axis_timestamp_tvalid(m_axis_timestamp_tvalid),
        .m_axis_timestamp_tready(m_axis_timestamp_tready),
        .cfg_enable(cfg_enable),
        .cfg_time_per_byte(cfg_time_per_byte),
        .cfg_empty_to_full(cfg_empty_to_full),
        .cfg_max_residence(cfg_max_residence),
        .state_clear(state_clear),
        .discard_count(discard_count),
        .eligible_count(eligible_count)
    );

    typedef struct {
        logic [15:0]   len;
        logic [TS-1:0] arr;
        logic          en;
        logic [TS-1:0] mrt;
        logic [TS-1:0] exp_data;
        logic [TS-1:0] exp_bucket;
        int            exp_elig;
        int            exp_disc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [TS-1:0] got, input logic [TS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Drives one request, scrambles inputs/cfg after acceptance, and returns tdata seen at handshake+3.
    task automatic run_req(input string tag, input logic [15:0] len, input logic [TS-1:0] arr,
                           input logic en, input logic [TS-1:0] mrt, output logic [TS-1:0] data);
        int n = 0;
        cfg_enable = en;
        cfg_max_residence = mrt;
        cfg_time_per_byte = TPB;
        cfg_empty_to_full = E2F;
        s_req_frame_len = len;
        s_req_arrival_time = arr;
        s_req_valid = 1'b1;
        while (!s_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, TS'(s_req_ready), TS'(1));
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        s_req_frame_len = 16'($urandom);
        s_req_arrival_time = TS'($urandom);
        cfg_enable = ~en;
        cfg_time_per_byte = 24'($urandom);
        cfg_empty_to_full = TS'($urandom);
        cfg_max_residence = TS'($urandom_range(10, 0));
        check({tag, "_tvalid_mul"}, TS'(m_axis_timestamp_tvalid), TS'(0));
        @(posedge clk); #1;
        check({tag, "_tvalid_cmp"}, TS'(m_axis_timestamp_tvalid), TS'(0));
        @(posedge clk); #1;
        check({tag, "_tvalid_out"}, TS'(m_axis_timestamp_tvalid), TS'(1));
        data = m_axis_timestamp_tdata;
        cfg_enable = en;
        cfg_time_per_byte = TPB;
        cfg_empty_to_full = E2F;
        cfg_max_residence = mrt;
    endtask

    initial begin
        logic [TS-1:0] got;
        vecs[0] = '{16'd1000, 72'd50000, 1'b1, 72'd100000, 72'd50000, 72'd46000, 1, 0};
        vecs[1] = '{16'd1000, 72'd50010, 1'b1, 72'd100000, 72'd54000, 72'd54000, 2, 0};
        vecs[2] = '{16'd1500, 72'd50020, 1'b1, 72'd5000,   72'd0,     72'd54000, 2, 1};
        vecs[3] = '{16'd300,  72'd0,     1'b0, 72'd100000, 72'd1,     72'd54000, 3, 1};
        vecs[4] = '{16'd500,  72'd777,   1'b0, 72'd100000, 72'd777,   72'd54000, 4, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", TS'(m_axis_timestamp_tvalid), TS'(0));
        check("rst_tdata", m_axis_timestamp_tdata, TS'(0));
        check("rst_ready", TS'(s_req_ready), TS'(0));
        check("rst_elig_cnt", TS'(eligible_count), TS'(0));
        check("rst_disc_cnt", TS'(discard_count), TS'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", TS'(s_req_ready), TS'(1));

        state_clear = 1'b1;
        s_req_valid = 1'b1;
        #1;
        check("clear_blocks_ready", TS'(s_req_ready), TS'(0));
        @(posedge clk); #1;
        state_clear = 1'b0;
        s_req_valid = 1'b0;
        check("clear_no_accept_tvalid", TS'(m_axis_timestamp_tvalid), TS'(0));
        #1;
        check("clear_ready_back", TS'(s_req_ready), TS'(1));

        for (int i = 0; i < 5; i++) begin
            run_req($sformatf("v%0d", i), vecs[i].len, vecs[i].arr, vecs[i].en, vecs[i].mrt, got);
            check($sformatf("v%0d_tdata", i), got, vecs[i].exp_data);
            @(posedge clk); #1;
            check($sformatf("v%0d_tvalid_drop", i), TS'(m_axis_timestamp_tvalid), TS'(0));
            check($sformatf("v%0d_bucket", i), dut.bucket_empty_time, vecs[i].exp_bucket);
            check($sformatf("v%0d_elig_cnt", i), TS'(eligible_count), TS'(vecs[i].exp_elig));
            check($sformatf("v%0d_disc_cnt", i), TS'(discard_count), TS'(vecs[i].exp_disc));
        end
        check("v1_group", dut.group_elig_time, 72'd54000);

        m_axis_timestamp_tready = 1'b0;
        run_req("bp", 16'd1000, 72'd60000, 1'b1, 72'd100000, got);
        check("bp_tdata", got, 72'd62000);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            state_clear = (k == 2);
            check($sformatf("bp_hold_tvalid%0d", k), TS'(m_axis_timestamp_tvalid), TS'(1));
            check($sformatf("bp_hold_tdata%0d", k), m_axis_timestamp_tdata, 72'd62000);
            check($sformatf("bp_hold_ready%0d", k), TS'(s_req_ready), TS'(0));
        end
        m_axis_timestamp_tready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_tvalid", TS'(m_axis_timestamp_tvalid), TS'(0));
        check("bp_pending_ready", TS'(s_req_ready), TS'(0));
        check("bp_bucket_preclear", dut.bucket_empty_time, 72'd62000);
        check("bp_elig_cnt", TS'(eligible_count), TS'(5));
        @(posedge clk); #1;
        check("clr_bucket", dut.bucket_empty_time, TS'(0));
        check("clr_group", dut.group_elig_time, TS'(0));
        check("clr_ready", TS'(s_req_ready), TS'(1));
        run_req("post_clr", 16'd1000, 72'd100, 1'b1, 72'd100000, got);
        check("post_clr_tdata", got, 72'd8000);
        @(posedge clk); #1;
        check("post_clr_bucket", dut.bucket_empty_time, 72'd8000);
        check("post_clr_elig_cnt", TS'(eligible_count), TS'(6));

        s_req_frame_len = 16'd1000;
        s_req_arrival_time = 72'd90000;
        s_req_valid = 1'b1;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_tvalid", TS'(m_axis_timestamp_tvalid), TS'(0));
        check("midrst_tdata", m_axis_timestamp_tdata, TS'(0));
        check("midrst_ready", TS'(s_req_ready), TS'(0));
        check("midrst_elig_cnt", TS'(eligible_count), TS'(0));
        check("midrst_disc_cnt", TS'(discard_count), TS'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_no_stale%0d", k), TS'(m_axis_timestamp_tvalid), TS'(0));
        end
        run_req("rerun", vecs[0].len, vecs[0].arr, 1'b1, 72'd100000, got);
        check("rerun_tdata", got, 72'd50000);
        @(posedge clk); #1;
        check("rerun_bucket", dut.bucket_empty_time, 72'd46000);
        check("rerun_group", dut.group_elig_time, 72'd50000);
        check("rerun_elig_cnt", TS'(eligible_count), TS'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ats_eligibility_scheduler.md
Name: ats_eligibility_scheduler

Overview:
- Per-stream ATS (802.1Qcr) token-bucket scheduler that produces the timestamp stream consumed by the frame/timestamp joining stage.
- For each frame request (length, arrival time) it computes the eligibility time, or 0 meaning "discard", and updates bucket state.
- Sits between frame-length/arrival capture and the timestamp input of the timestamp-attach datapath.
- One instance per stream filter.

Parameters:
- TIMESTAMP_WIDTH, 72, width of all time values (ns, unsigned, no wrap handling).
- LEN_WIDTH, 16, frame length field (bytes).
- TPB_WIDTH, 24, cfg_time_per_byte width.
- TPB_FRAC_BITS, 8, fractional bits of cfg_time_per_byte.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_req_frame_len  in  LEN_WIDTH  frame length, bytes
- s_req_arrival_time  in  TIMESTAMP_WIDTH  arrival timestamp
- s_req_valid  in  1  request valid
- s_req_ready  out  1  request accept
- m_axis_timestamp_tdata  out  TIMESTAMP_WIDTH  eligibility time; 0 = discard
- m_axis_timestamp_tvalid  out  1  result valid
- m_axis_timestamp_tready  in  1  downstream accept
- cfg_enable  in  1  0 = bypass (eligibility = arrival)
- cfg_time_per_byte  in  TPB_WIDTH  ns/byte fixed point (1/CIR)
- cfg_empty_to_full  in  TIMESTAMP_WIDTH  CBS/CIR duration, ns
- cfg_max_residence  in  TIMESTAMP_WIDTH  max residence time, ns
- state_clear  in  1  pulse: zero bucket_empty_time and group_elig_time
- discard_count  out  CNT_WIDTH  saturating discarded-frame count
- eligible_count  out  CNT_WIDTH  saturating passed-frame count

Behaviour:
- Reset (async assert, sync release): state IDLE; s_req_ready=0 while rst; m_axis_timestamp_tvalid=0, tdata=0; bucket_empty_time=0; group_elig_time=0; both counters 0; clear_pending=0.
- FSM states IDLE, MUL, CMP, OUT.
- IDLE:
  - s_req_ready = !state_clear && !clear_pending.
  - On handshake, latch len, arrival and all cfg_* values; go to MUL.
  - Cfg changes after acceptance do not affect the in-flight request.
- MUL: len_dur = ceil(len * cfg_time_per_byte / 2^TPB_FRAC_BITS), i.e. round up; full-width product, zero-extended to TIMESTAMP_WIDTH. Go to CMP.
- CMP:
  - sched = bucket_empty_time + len_dur.
  - full = bucket_empty_time + e2f.
  - elig = max(arrival, group_elig_time, sched).
  - If elig <= arrival + mrt (inclusive):
    - Result = elig.
    - group_elig_time <= elig.
    - bucket_empty_time <= (elig < full) ? sched : sched + elig - full.
    - eligible_count++.
  - Else: result = 0; bucket and group state unchanged; discard_count++.
  - A passed result of value 0 is output as 1, because 0 is reserved for discard.
  - cfg_enable=0: result = arrival (0 maps to 1), no state update, eligible_count++.
  - Go to OUT.
- OUT:
  - tvalid=1; tdata held stable until tready.
  - On handshake go to IDLE, with tvalid low that cycle.
- Latency: request handshake at cycle N gives tvalid at N+3. Maximum throughput is 1 result per 4 cycles.
- state_clear:
  - In IDLE it applies next edge and has priority over a same-cycle request (ready is low).
  - In MUL/CMP/OUT it sets clear_pending. The in-flight request completes with pre-clear state, and the clear is applied on return to IDLE before any new accept.
- Counters saturate at all-ones.
- Reset mid-operation aborts the in-flight request; no output is produced for it.
- Adder overflow beyond TIMESTAMP_WIDTH is not handled. 72-bit ns does not wrap in service life.

Decomposition:
- Shared package ats_pkg: TIMESTAMP_WIDTH default, FSM state encoding constants, DISCARD_TIMESTAMP = 0.
- Sub-module ats_len_duration: registered ceil fixed-point multiply used in MUL. Single cycle; parameterised LEN_WIDTH/TPB_WIDTH/TPB_FRAC_BITS.
- Everything else lives in this module.

Test Plan:
- Common config: tpb=8.0 (0x000800), e2f=12000, mrt=100000, enable=1.
- After reset: req len=1000, arrival=50000 -> tdata=50000 at +3 cycles; internal bucket_empty=46000, group=50000; eligible_count=1.
- Follow-on req len=1000, arrival=50010 -> tdata=54000; bucket_empty=54000.
- Set mrt=5000; req len=1500, arrival=50020 -> sched=66000 > 55020, tdata=0; discard_count=1; bucket_empty remains 54000.
- enable=0: req arrival=0 -> tdata=1; req arrival=777 -> tdata=777; no state change.
- Backpressure: tready low for 10 cycles in OUT -> tdata/tvalid stable, s_req_ready=0. Pulse state_clear during OUT -> result unchanged. Next req len=1000, arrival=100 -> tdata=8000, since the bucket was cleared.
- Assert rst in MUL -> tvalid=0 and counters=0 immediately, no stale output after release. Next request behaves as in the first scenario.
